// File: rtl/muldiv_seq.sv
// Iterative 32-bit multiply/divide sequencer for the LA32R EX stage.
// A single shared shift/add-subtract datapath handles mul.w, mulh.w[u], div.w[u] and mod.w[u].
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            cpu_clk,
  input  logic            cpu_rst,
  input  logic            start,
  input  logic [2:0]      md_op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  input  logic            ack,
  output logic            stall_req,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PREP  = 3'd1;
  localparam logic [2:0] S_CALC  = 3'd2;
  localparam logic [2:0] S_FIXUP = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [2:0] OP_MUL_W   = 3'd0;
  localparam logic [2:0] OP_MULH_W  = 3'd1;
  localparam logic [2:0] OP_MULH_WU = 3'd2;
  localparam logic [2:0] OP_DIV_W   = 3'd3;
  localparam logic [2:0] OP_MOD_W   = 3'd4;
  localparam logic [2:0] OP_DIV_WU  = 3'd5;
  localparam logic [2:0] OP_MOD_WU  = 3'd6;
  localparam logic [2:0] OP_RSVD    = 3'd7;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic [2*XLEN-1:0] acc;
  logic              neg_a;
  logic              neg_b;

  logic              is_div;
  logic              is_signed;
  logic              div_zero;
  logic              accept;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN+1:0]   alu_x;
  logic [XLEN+1:0]   alu_y;
  logic [XLEN+1:0]   alu_sum;
  logic [2*XLEN-1:0] step_acc;
  logic [2*XLEN-1:0] prod_neg;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fix_result;

  assign is_div    = (op_q >= OP_DIV_W) && (op_q != OP_RSVD);
  assign is_signed = (op_q == OP_MULH_W) || (op_q == OP_DIV_W) || (op_q == OP_MOD_W);
  assign div_zero  = is_div && (b_q == '0);
  assign accept    = (state == S_IDLE) && start && (md_op != OP_RSVD) && !flush;
  assign mag_a     = (is_signed && a_q[XLEN-1]) ? -a_q : a_q;
  assign mag_b     = (is_signed && b_q[XLEN-1]) ? -b_q : b_q;

  // Multiply adds the multiplicand into the high half then shifts right;
  // divide shifts the remainder left and does a restoring trial subtract.
  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    alu_x    = '0;
    alu_y    = '0;
    alu_sum  = '0;
    step_acc = acc;
    if (is_div) begin
      alu_x    = {1'b0, acc[2*XLEN-1:XLEN-1]};
      alu_y    = {2'b00, b_q};
      alu_sum  = alu_x - alu_y;
      step_acc = {alu_sum[XLEN+1] ? acc[2*XLEN-2:XLEN-1] : alu_sum[XLEN-1:0],
                  acc[XLEN-2:0], ~alu_sum[XLEN+1]};
    end else begin
      alu_x    = {2'b00, acc[2*XLEN-1:XLEN]};
      alu_y    = acc[0] ? {2'b00, b_q} : '0;
      alu_sum  = alu_x + alu_y;
      step_acc = {alu_sum[XLEN:0], acc[XLEN-1:1]};
    end
  end

  assign prod_neg = -acc;
  assign quo      = acc[XLEN-1:0];
  assign rem      = acc[2*XLEN-1:XLEN];

  // Sign flags are only set for signed ops, so unsigned ops fall through uncorrected.
  always_comb begin
    fix_result = '0;
    case (op_q)
      OP_MUL_W:   fix_result = acc[XLEN-1:0];
      OP_MULH_W:  fix_result = (neg_a ^ neg_b) ? prod_neg[2*XLEN-1:XLEN] : rem;
      OP_MULH_WU: fix_result = rem;
      OP_DIV_W, OP_DIV_WU:
        fix_result = div_zero ? '1 : ((neg_a ^ neg_b) ? -quo : quo);
      OP_MOD_W, OP_MOD_WU:
        fix_result = div_zero ? a_q : (neg_a ? -rem : rem);
      default:    fix_result = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      result <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start && (md_op != OP_RSVD)) state <= S_PREP;
        S_PREP: begin
          cnt   <= '0;
          state <= div_zero ? S_FIXUP : S_CALC;
        end
        S_CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) state <= S_FIXUP;
        end
        S_FIXUP: begin
          result <= fix_result;
          state  <= S_DONE;
        end
        S_DONE:  if (ack) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: datapath registers carry no reset; each is loaded in IDLE/PREP before it is ever read.
  always_ff @(posedge cpu_clk) begin
    case (state)
      S_IDLE: begin
        op_q <= md_op;
        a_q  <= src_a;
        b_q  <= src_b;
      end
      S_PREP: begin
        acc   <= {{XLEN{1'b0}}, mag_a};
        b_q   <= mag_b;
        neg_a <= is_signed && a_q[XLEN-1];
        neg_b <= is_signed && b_q[XLEN-1];
      end
      S_CALC:  acc <= step_acc;
      default: ;
    endcase
  end

  assign stall_req = !cpu_rst &&
                     (accept || (state == S_PREP) || (state == S_CALC) || (state == S_FIXUP));
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed boundary cases plus random ops,
// scored against a plain-arithmetic reference model via an expected-result queue.
module tb_muldiv_seq;

  localparam logic [2:0] MUL_W = 3'd0, MULH_W = 3'd1, MULH_WU = 3'd2, DIV_W = 3'd3,
                         MOD_W = 3'd4, DIV_WU = 3'd5, MOD_WU = 3'd6, RSVD = 3'd7;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        ack;
  logic        stall_req;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  bit          done_d = 1'b0;

  muldiv_seq dut (
    .cpu_clk   (cpu_clk),
    .cpu_rst   (cpu_rst),
    .start     (start),
    .md_op     (md_op),
    .src_a     (src_a),
    .src_b     (src_b),
    .flush     (flush),
    .ack       (ack),
    .stall_req (stall_req),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: 64-bit host arithmetic, truncating division.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] w;
    longint      sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MUL_W:   begin w = {32'd0, a} * {32'd0, b}; return w[31:0]; end
      MULH_W:  begin w = sa * sb;                 return w[63:32]; end
      MULH_WU: begin w = {32'd0, a} * {32'd0, b}; return w[63:32]; end
      DIV_W:   begin if (b == 0) return 32'hFFFF_FFFF; w = sa / sb; return w[31:0]; end
      MOD_W:   begin if (b == 0) return a;             w = sa % sb; return w[31:0]; end
      DIV_WU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      MOD_WU:  return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Monitor: scores every fresh done against the oldest queued expectation.
  always @(negedge cpu_clk) begin
    if (done && !done_d) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got result %h with no operation pending", result);
      end else begin
        check("result", result, exp_q.pop_front());
      end
    end
    done_d = done;
  end

  task automatic wait_done(output int cycles, output int stalls);
    cycles = 0;
    stalls = 0;
    while (!done && cycles < 100) begin
      @(negedge cpu_clk);
      cycles++;
      if (stall_req) stalls++;
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    int          cycles, stalls, lat;
    logic [31:0] e;
    e   = model(op, a, b);
    lat = (op >= DIV_W && b == 0) ? 3 : 35;
    @(negedge cpu_clk);
    start = 1'b1; md_op = op; src_a = a; src_b = b; ack = 1'b0;
    exp_q.push_back(e);
    #1;
    check("stall_on_start", 32'(stall_req), 32'd1);
    wait_done(cycles, stalls);
    check("latency", 32'(cycles), 32'(lat));
    check("stall_cycles", 32'(stalls), 32'(lat - 1));
    check("stall_in_done", 32'(stall_req), 32'd0);
    repeat (hold) begin
      @(negedge cpu_clk);
      check("done_hold", 32'(done), 32'd1);
      check("result_hold", result, e);
    end
    ack = 1'b1; start = 1'b0;
    @(negedge cpu_clk);
    ack = 1'b0;
    check("idle_after_ack", {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int          cycles, stalls;
    logic [31:0] e, ra, rb;
    logic [2:0]  rop;

    cpu_rst = 1'b1; start = 1'b0; md_op = 3'd0; src_a = '0; src_b = '0;
    flush = 1'b0; ack = 1'b0;
    repeat (2) @(negedge cpu_clk);
    start = 1'b1;
    #1;
    check("reset_outputs", {29'd0, stall_req, busy, done}, 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge cpu_clk);
    start = 1'b0; cpu_rst = 1'b0;

    // Reserved opcode never starts anything.
    @(negedge cpu_clk);
    start = 1'b1; md_op = RSVD;
    #1;
    check("rsvd_stall", 32'(stall_req), 32'd0);
    @(negedge cpu_clk);
    check("rsvd_busy", 32'(busy), 32'd0);
    start = 1'b0;

    run_op(MUL_W,   32'hFFFF_FFFD, 32'd7,         0);
    run_op(MULH_W,  32'h8000_0000, 32'h8000_0000, 0);
    run_op(MULH_WU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    run_op(DIV_W,   32'hFFFF_FFF9, 32'd2,         0);
    run_op(MOD_W,   32'hFFFF_FFF9, 32'd2,         0);
    run_op(DIV_W,   32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(MOD_W,   32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(DIV_WU,  32'd5,         32'd0,         0);
    run_op(MOD_WU,  32'd5,         32'd0,         0);
    run_op(DIV_W,   32'hFFFF_FFF9, 32'd0,         0);
    run_op(MOD_W,   32'hFFFF_FFF9, 32'd0,         0);
    run_op(MUL_W,   32'h1234_5678, 32'h9ABC_DEF0, 4);

    // Flush in CALC at cnt=10; flush keeps beating a held start in IDLE.
    @(negedge cpu_clk);
    start = 1'b1; md_op = DIV_WU; src_a = 32'd1000; src_b = 32'd3;
    repeat (12) @(negedge cpu_clk);
    flush = 1'b1;
    @(negedge cpu_clk);
    #1;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_beats_start", 32'(stall_req), 32'd0);
    @(negedge cpu_clk);
    check("flush_hold_idle", {30'd0, busy, done}, 32'd0);
    flush = 1'b0; start = 1'b0;
    run_op(MUL_W, 32'hFFFF_FFFD, 32'd7, 0);

    // Flush in DONE drops the handshake but leaves the result register alone.
    e = model(MULH_WU, 32'hDEAD_BEEF, 32'h0000_1000);
    @(negedge cpu_clk);
    start = 1'b1; md_op = MULH_WU; src_a = 32'hDEAD_BEEF; src_b = 32'h0000_1000;
    exp_q.push_back(e);
    wait_done(cycles, stalls);
    check("flush_done_latency", 32'(cycles), 32'd35);
    start = 1'b0; flush = 1'b1;
    @(negedge cpu_clk);
    flush = 1'b0;
    check("flush_done_state", {30'd0, busy, done}, 32'd0);
    check("flush_done_result", result, e);

    // Reset in the middle of CALC.
    @(negedge cpu_clk);
    start = 1'b1; md_op = MUL_W; src_a = 32'h0F0F_0F0F; src_b = 32'd3;
    repeat (10) @(negedge cpu_clk);
    cpu_rst = 1'b1;
    #1;
    check("rst_stall_comb", 32'(stall_req), 32'd0);
    @(negedge cpu_clk);
    check("rst_mid_state", {29'd0, stall_req, busy, done}, 32'd0);
    check("rst_mid_result", result, 32'd0);
    cpu_rst = 1'b0; start = 1'b0;

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 6));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        3: rb = rb >> $urandom_range(16, 31);
        default: ;
      endcase
      run_op(rop, ra, rb, $urandom_range(0, 3));
    end

    repeat (3) @(negedge cpu_clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
